axi_gpio_banked: RTL and testbench

Parametrised AXI4-Lite GPIO peripheral, successor to the single-bank 32-pin GPIO. Organises pins into `N_BANKS` banks of `BANK_WIDTH` pins, each with its own register page. It adds two new per-pin features, both-edge interrupts and a toggle register, plus per-bank debounce and a per-bank IRQ output. It also adds SLVERR decoding for unmapped addresses. The block sits on the SoC AXI4-Lite peripheral bus, between the interconnect and the pads.

---
 rtl/axi_gpio_pkg.sv | 60 ++++++
 rtl/gpio_pin_filter.sv | 73 +++++++
 rtl/axi_gpio_banked.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_axi_gpio_banked.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_gpio_pkg
//  Description : Shared definitions for the banked AXI4-Lite GPIO peripheral:
//                register offsets, global page constants, AXI response
//                encoding, per-bank register record and a WSTRB helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial banked release
// ============================================================================
package axi_gpio_pkg;

    // Offsets inside one bank page (bank b lives at 0x100*b)
    localparam logic [7:0] OFF_DIR       = 8'h00;
    localparam logic [7:0] OFF_OUT       = 8'h04;
    localparam logic [7:0] OFF_OUT_SET   = 8'h08;
    localparam logic [7:0] OFF_OUT_CLR   = 8'h0C;
    localparam logic [7:0] OFF_IN        = 8'h10;
    localparam logic [7:0] OFF_IRQ_MASK  = 8'h14;
    localparam logic [7:0] OFF_IRQ_STAT  = 8'h18;
    localparam logic [7:0] OFF_IRQ_CLR   = 8'h1C;
    localparam logic [7:0] OFF_EDGE_EN   = 8'h20;
    localparam logic [7:0] OFF_EDGE_POL  = 8'h24;
    localparam logic [7:0] OFF_LVL_POL   = 8'h28;
    localparam logic [7:0] OFF_EDGE_BOTH = 8'h2C;
    localparam logic [7:0] OFF_DEBOUNCE  = 8'h30;
    localparam logic [7:0] OFF_OUT_TGL   = 8'h34;

    // Global page
    localparam logic [11:0] GLOBAL_BASE  = 12'hF00;
    localparam logic [7:0]  G_VERSION    = 8'h00;
    localparam logic [7:0]  G_BANK_IRQ   = 8'h04;
    localparam logic [7:0]  G_CONFIG     = 8'h08;
    localparam logic [7:0]  G_SCRATCH    = 8'h0C;
    localparam logic [31:0] VERSION      = 32'h0002_0000;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    // Registers of one bank; fields are stored 32 bits wide and masked to
    // the bank width so that upper bits always read back as zero.
    typedef struct packed {
        logic [31:0] dir;
        logic [31:0] out;
        logic [31:0] mask;
        logic [31:0] status;
        logic [31:0] edge_en;
        logic [31:0] edge_pol;
        logic [31:0] lvl_pol;
        logic [31:0] edge_both;
        logic [31:0] debounce;
    } bank_regs_t;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_pin_filter.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pin_filter
//  Description : Per-pin input conditioning for one bank: 2-FF synchroniser,
//                debounce counter, debounced value and its one-cycle delay.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_raw             - asynchronous pad inputs
//                i_debounce        - stable cycles required (0/1 = bypass)
//                o_db, o_db_prev   - debounced value and previous value
//  Revision    : 1.0 - initial banked release
// ============================================================================
module gpio_pin_filter #(
    parameter int WIDTH      = 32,
    parameter int DEBOUNCE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      i_raw,
    input  logic [DEBOUNCE_W-1:0] i_debounce,
    output logic [WIDTH-1:0]      o_db,
    output logic [WIDTH-1:0]      o_db_prev
);

    logic [WIDTH-1:0]      r_sync1;
    logic [WIDTH-1:0]      r_sync2;
    logic [WIDTH-1:0]      r_db;
    logic [WIDTH-1:0]      r_db_prev;
    logic [DEBOUNCE_W-1:0] r_cnt [WIDTH];

    logic                  w_bypass;
    logic [DEBOUNCE_W-1:0] w_limit;

    assign w_bypass = (i_debounce <= DEBOUNCE_W'(1));
    assign w_limit  = i_debounce - DEBOUNCE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_bypass) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else if (r_sync2[i] != r_db[i]) begin
                    // The counter reaches D-1 on the D-th differing cycle,
                    // so a pulse must last D cycles to be accepted.
                    if (r_cnt[i] == w_limit) begin
                        r_db[i]  <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + DEBOUNCE_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign o_db      = r_db;
    assign o_db_prev = r_db_prev;

endmodule
`default_nettype wire

// File: rtl/axi_gpio_banked.sv
`default_nettype none
// ============================================================================
//  Module      : axi_gpio_banked
//  Description : AXI4-Lite GPIO with N_BANKS pages of BANK_WIDTH pins. Each
//                bank has direction/output/toggle registers, edge/level/both-
//                edge interrupts, debounce and its own IRQ line.
//  Ports       : aclk, areset            - clock, synchronous active-high reset
//                aw*/w*/b*, ar*/r*       - AXI4-Lite slave
//                gpio_in_raw             - asynchronous pad inputs
//                gpio_out, gpio_oe       - OUT and DIR register values
//                irq_bank, irq           - per-bank and combined interrupts
//  Revision    : 1.0 - initial banked release
// ============================================================================
module axi_gpio_banked
    import axi_gpio_pkg::*;
#(
    parameter int N_BANKS        = 2,
    parameter int BANK_WIDTH     = 32,
    parameter int DEBOUNCE_W     = 8,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     araddr,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [AXI_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                    rresp,
    output logic                          rvalid,
    input  logic                          rready,
    input  logic [N_BANKS*BANK_WIDTH-1:0] gpio_in_raw,
    output logic [N_BANKS*BANK_WIDTH-1:0] gpio_out,
    output logic [N_BANKS*BANK_WIDTH-1:0] gpio_oe,
    output logic [N_BANKS-1:0]            irq_bank,
    output logic                          irq
);

    localparam logic [31:0] c_BANK_MASK = 32'((64'd1 << BANK_WIDTH) - 64'd1);
    localparam logic [31:0] c_DB_MASK   = 32'((64'd1 << DEBOUNCE_W) - 64'd1);
    localparam logic [31:0] c_CONFIG    = {8'd0, 8'(DEBOUNCE_W), 8'(BANK_WIDTH), 8'(N_BANKS)};
    localparam logic [3:0]  c_GPAGE     = GLOBAL_BASE[11:8];

    // Registers
    bank_regs_t                r_bank [N_BANKS];
    logic [31:0]               r_scratch;
    logic                      r_up;          // low during and one cycle after reset
    logic                      r_aw_full;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
    logic                      r_w_full;
    logic [31:0]               r_w_data;
    logic [3:0]                r_w_strb;
    logic                      r_bvalid;
    axi_resp_e                 r_bresp;
    logic                      r_rvalid;
    logic [31:0]               r_rdata;
    axi_resp_e                 r_rresp;

    // Combinational
    bank_regs_t                w_bank_nxt [N_BANKS];
    logic [31:0]               w_scratch_nxt;
    logic [BANK_WIDTH-1:0]     w_event [N_BANKS];
    logic [BANK_WIDTH-1:0]     w_in    [N_BANKS];
    logic                      w_commit;
    logic                      w_wr_ok;
    logic [3:0]                w_wr_page;
    logic [7:0]                w_wr_off;
    logic [31:0]               w_wm;
    logic [31:0]               w_wd;
    logic [31:0]               w_clr;
    logic                      w_rd_ok;
    logic [3:0]                w_rd_page;
    logic [7:0]                w_rd_off;
    logic [31:0]               w_rd_data;

    // A mapped address is either a defined global offset or a defined offset
    // inside an existing bank page; everything above 12 bits must be zero.
    function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [3:0] page;
        logic [7:0] off;
        logic       ok;
        page = a[11:8];
        off  = {a[7:2], 2'b00};
        ok   = 1'b0;
        if (page == c_GPAGE) begin
            ok = (off <= G_SCRATCH);
        end else if ({4'd0, page} < 8'(N_BANKS)) begin
            ok = (off <= OFF_OUT_TGL);
        end
        return ok && ((a >> 12) == '0);
    endfunction

    // ------------------------------------------------------------------
    // Per-bank input filtering, event generation and outputs
    // ------------------------------------------------------------------
    for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_bank
        logic [BANK_WIDTH-1:0] w_db;
        logic [BANK_WIDTH-1:0] w_db_prev;
        logic [BANK_WIDTH-1:0] w_en;
        logic [BANK_WIDTH-1:0] w_pol;
        logic [BANK_WIDTH-1:0] w_lvl;
        logic [BANK_WIDTH-1:0] w_both;
        logic [BANK_WIDTH-1:0] w_edge;

        gpio_pin_filter #(
            .WIDTH      (BANK_WIDTH),
            .DEBOUNCE_W (DEBOUNCE_W)
        ) u_filter (
            .clk        (aclk),
            .rst        (areset),
            .i_raw      (gpio_in_raw[gb*BANK_WIDTH +: BANK_WIDTH]),
            .i_debounce (r_bank[gb].debounce[DEBOUNCE_W-1:0]),
            .o_db       (w_db),
            .o_db_prev  (w_db_prev)
        );

        assign w_en   = r_bank[gb].edge_en[BANK_WIDTH-1:0];
        assign w_pol  = r_bank[gb].edge_pol[BANK_WIDTH-1:0];
        assign w_lvl  = r_bank[gb].lvl_pol[BANK_WIDTH-1:0];
        assign w_both = r_bank[gb].edge_both[BANK_WIDTH-1:0];

        assign w_edge = (w_both & (w_db ^ w_db_prev))
                      | (~w_both &  w_pol &  w_db & ~w_db_prev)
                      | (~w_both & ~w_pol & ~w_db &  w_db_prev);

        assign w_event[gb] = (w_en & w_edge) | (~w_en & ~(w_db ^ w_lvl));
        assign w_in[gb]    = w_db;

        assign irq_bank[gb] = |(r_bank[gb].status & r_bank[gb].mask);
        assign gpio_out[gb*BANK_WIDTH +: BANK_WIDTH] = r_bank[gb].out[BANK_WIDTH-1:0];
        assign gpio_oe[gb*BANK_WIDTH +: BANK_WIDTH]  = r_bank[gb].dir[BANK_WIDTH-1:0];
    end

    assign irq = |irq_bank;

    // ------------------------------------------------------------------
    // Write decode and register next state
    // ------------------------------------------------------------------
    assign w_commit  = r_aw_full && r_w_full && !r_bvalid;
    assign w_wr_ok   = addr_ok(r_aw_addr);
    assign w_wr_page = r_aw_addr[11:8];
    assign w_wr_off  = {r_aw_addr[7:2], 2'b00};
    assign w_wm      = strb_to_mask(r_w_strb);
    assign w_wd      = r_w_data & w_wm;

    always_comb begin : p_next
        w_bank_nxt    = r_bank;
        w_scratch_nxt = r_scratch;
        w_clr         = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            w_clr = '0;
            if (w_commit && w_wr_ok && (w_wr_page == 4'(b))) begin
                case (w_wr_off)
                    OFF_DIR:       w_bank_nxt[b].dir       = ((r_bank[b].dir & ~w_wm) | w_wd) & c_BANK_MASK;
                    OFF_OUT:       w_bank_nxt[b].out       = ((r_bank[b].out & ~w_wm) | w_wd) & c_BANK_MASK;
                    OFF_OUT_SET:   w_bank_nxt[b].out       = (r_bank[b].out | w_wd) & c_BANK_MASK;
                    OFF_OUT_CLR:   w_bank_nxt[b].out       = r_bank[b].out & ~w_wd;
                    OFF_OUT_TGL:   w_bank_nxt[b].out       = (r_bank[b].out ^ w_wd) & c_BANK_MASK;
                    OFF_IRQ_MASK:  w_bank_nxt[b].mask      = ((r_bank[b].mask & ~w_wm) | w_wd) & c_BANK_MASK;
                    OFF_IRQ_CLR:   w_clr                   = w_wd;
                    OFF_EDGE_EN:   w_bank_nxt[b].edge_en   = ((r_bank[b].edge_en & ~w_wm) | w_wd) & c_BANK_MASK;
                    OFF_EDGE_POL:  w_bank_nxt[b].edge_pol  = ((r_bank[b].edge_pol & ~w_wm) | w_wd) & c_BANK_MASK;
                    OFF_LVL_POL:   w_bank_nxt[b].lvl_pol   = ((r_bank[b].lvl_pol & ~w_wm) | w_wd) & c_BANK_MASK;
                    OFF_EDGE_BOTH: w_bank_nxt[b].edge_both = ((r_bank[b].edge_both & ~w_wm) | w_wd) & c_BANK_MASK;
                    OFF_DEBOUNCE:  w_bank_nxt[b].debounce  = ((r_bank[b].debounce & ~w_wm) | w_wd) & c_DB_MASK;
                    default: ;
                endcase
            end
            // Clear first, then OR in new events: a simultaneous set wins.
            w_bank_nxt[b].status = ((r_bank[b].status & ~w_clr) | 32'(w_event[b])) & c_BANK_MASK;
        end
        if (w_commit && w_wr_ok && (w_wr_page == c_GPAGE) && (w_wr_off == G_SCRATCH)) begin
            w_scratch_nxt = (r_scratch & ~w_wm) | w_wd;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (sampled at the AR handshake)
    // ------------------------------------------------------------------
    assign w_rd_page = araddr[11:8];
    assign w_rd_off  = {araddr[7:2], 2'b00};

    always_comb begin : p_rd_mux
        w_rd_ok   = addr_ok(araddr);
        w_rd_data = '0;
        if (w_rd_ok) begin
            if (w_rd_page == c_GPAGE) begin
                case (w_rd_off)
                    G_VERSION:  w_rd_data = VERSION;
                    G_BANK_IRQ: w_rd_data = 32'(irq_bank);
                    G_CONFIG:   w_rd_data = c_CONFIG;
                    G_SCRATCH:  w_rd_data = r_scratch;
                    default:    w_rd_data = '0;
                endcase
            end else begin
                for (int b = 0; b < N_BANKS; b++) begin
                    if (w_rd_page == 4'(b)) begin
                        case (w_rd_off)
                            OFF_DIR:       w_rd_data = r_bank[b].dir;
                            OFF_OUT:       w_rd_data = r_bank[b].out;
                            OFF_IN:        w_rd_data = 32'(w_in[b]);
                            OFF_IRQ_MASK:  w_rd_data = r_bank[b].mask;
                            OFF_IRQ_STAT:  w_rd_data = r_bank[b].status;
                            OFF_EDGE_EN:   w_rd_data = r_bank[b].edge_en;
                            OFF_EDGE_POL:  w_rd_data = r_bank[b].edge_pol;
                            OFF_LVL_POL:   w_rd_data = r_bank[b].lvl_pol;
                            OFF_EDGE_BOTH: w_rd_data = r_bank[b].edge_both;
                            OFF_DEBOUNCE:  w_rd_data = r_bank[b].debounce;
                            default:       w_rd_data = '0;  // pulse registers
                        endcase
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int b = 0; b < N_BANKS; b++) begin
                r_bank[b]          <= '0;
                r_bank[b].edge_pol <= c_BANK_MASK;
                r_bank[b].lvl_pol  <= c_BANK_MASK;
            end
            r_scratch <= '0;
            r_up      <= 1'b0;
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_bank    <= w_bank_nxt;
            r_scratch <= w_scratch_nxt;
            r_up      <= 1'b1;

            if (awvalid && awready) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= awaddr;
            end
            if (wvalid && wready) begin
                r_w_full <= 1'b1;
                r_w_data <= 32'(wdata);
                r_w_strb <= 4'(wstrb);
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && bready) begin
                r_bvalid  <= 1'b0;
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end

            if (arvalid && arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign awready = r_up && !r_aw_full && !r_bvalid;
    assign wready  = r_up && !r_w_full && !r_bvalid;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_up && !r_rvalid;
    assign rvalid  = r_rvalid;
    assign rdata   = AXI_DATA_WIDTH'(r_rdata);
    assign rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_gpio_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_gpio_banked
//  Description : Self-checking bench for axi_gpio_banked (default params).
//                Expected responses are queued when a transaction is issued
//                and compared when the DUT returns its response.
//  Revision    : 1.0 - initial banked release
// ============================================================================
module tb_axi_gpio_banked;

    localparam int c_NB = 2;
    localparam int c_BW = 32;

    logic              aclk = 1'b0;
    logic              areset;
    logic [11:0]       awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [11:0]       araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [c_NB*c_BW-1:0] gpio_in_raw;
    logic [c_NB*c_BW-1:0] gpio_out;
    logic [c_NB*c_BW-1:0] gpio_oe;
    logic [c_NB-1:0]   irq_bank;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] rd_q [$];   // {resp, data}
    logic [1:0]  wr_q [$];

    always #5 aclk = ~aclk;

    axi_gpio_banked #(
        .N_BANKS        (c_NB),
        .BANK_WIDTH     (c_BW),
        .DEBOUNCE_W     (8),
        .AXI_ADDR_WIDTH (12),
        .AXI_DATA_WIDTH (32)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .gpio_in_raw (gpio_in_raw),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq_bank    (irq_bank),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic axi_rd(input string tag, input logic [11:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [33:0] e;
        int n;
        rd_q.push_back({exp_resp, exp_data});
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            step(1);
            n++;
        end
        step(1);
        arvalid = 1'b0;
        check({tag, "_rvalid_lat"}, rvalid, 1);
        n = 0;
        while (!rvalid && n < 50) begin
            step(1);
            n++;
        end
        e = rd_q.pop_front();
        check({tag, "_rdata"}, rdata, e[31:0]);
        check({tag, "_rresp"}, rresp, e[33:32]);
        rready = 1'b1;
        step(1);
        rready = 1'b0;
    endtask

    task automatic axi_wr(input string tag, input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp, input int hold);
        logic [1:0] e;
        logic a_hs;
        logic w_hs;
        int n;
        wr_q.push_back(exp_resp);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = (hold == 0);
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            step(1);
            if (a_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!bvalid && n < 50) begin
            step(1);
            n++;
        end
        e = wr_q.pop_front();
        check({tag, "_bvalid"}, bvalid, 1);
        check({tag, "_bresp"}, bresp, e);
        for (int i = 0; i < hold; i++) begin
            step(1);
            check({tag, "_hold_awready"}, awready, 0);
            check({tag, "_hold_wready"}, wready, 0);
            check({tag, "_hold_bvalid"}, bvalid, 1);
            check({tag, "_hold_bresp"}, bresp, e);
        end
        bready = 1'b1;
        step(1);
        bready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        gpio_in_raw = '0;

        // Reset state
        step(3);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_irq", irq, 0);
        check("rst_gpio_oe", gpio_oe, 0);
        areset = 1'b0;
        step(2);

        // Identification
        axi_rd("version", 12'hF00, 32'h0002_0000, 2'b00);
        axi_rd("config", 12'hF08, 32'h0008_2002, 2'b00);
        axi_rd("edge_pol_rst", 12'h124, 32'hFFFF_FFFF, 2'b00);
        axi_rd("bank_irq_rst", 12'hF04, 32'h0, 2'b00);

        // Bank 1 output path
        axi_wr("b1_dir", 12'h100, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
        check("b1_gpio_oe", gpio_oe, {32'hFFFF_FFFF, 32'h0});
        axi_wr("b1_out", 12'h104, 32'h0000_0F0F, 4'hF, 2'b00, 0);
        axi_wr("b1_tgl", 12'h134, 32'h0000_FFFF, 4'hF, 2'b00, 0);
        axi_rd("b1_out_rb", 12'h104, 32'h0000_F0F0, 2'b00);
        check("b1_gpio_out", gpio_out, {32'h0000_F0F0, 32'h0});
        axi_rd("b1_tgl_rb", 12'h134, 32'h0, 2'b00);
        axi_wr("b1_set_strb", 12'h108, 32'hFFFF_FFFF, 4'b0100, 2'b00, 0);
        axi_rd("b1_set_rb", 12'h104, 32'h00FF_F0F0, 2'b00);
        axi_wr("b1_clr", 12'h10C, 32'h00FF_0000, 4'hF, 2'b00, 0);
        check("b1_gpio_out2", gpio_out, {32'h0000_F0F0, 32'h0});

        // Both-edge interrupt, bank 0 pin 3
        axi_wr("b0_edge_en", 12'h020, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
        axi_wr("b0_edge_both", 12'h02C, 32'h8, 4'hF, 2'b00, 0);
        axi_wr("b0_mask", 12'h014, 32'h8, 4'hF, 2'b00, 0);
        check("irq_idle", irq, 0);
        gpio_in_raw[3] = 1'b1;
        step(3);
        check("both_rise_irq_e3", irq, 0);
        step(1);
        check("both_rise_irq_e4", irq, 1);
        check("both_rise_irq_bank", irq_bank, 2'b01);
        axi_rd("both_rise_stat", 12'h018, 32'h8, 2'b00);
        axi_rd("both_bank_irq", 12'hF04, 32'h1, 2'b00);
        axi_rd("in_pin3", 12'h010, 32'h8, 2'b00);
        axi_wr("both_clr", 12'h01C, 32'h8, 4'hF, 2'b00, 0);
        axi_rd("both_clr_stat", 12'h018, 32'h0, 2'b00);
        check("both_clr_irq", irq, 0);
        gpio_in_raw[3] = 1'b0;
        step(6);
        axi_rd("both_fall_stat", 12'h018, 32'h8, 2'b00);
        axi_wr("both_clr2", 12'h01C, 32'h8, 4'hF, 2'b00, 0);

        // Debounce, bank 0 pin 2 in rising mode
        axi_wr("db_set", 12'h030, 32'h4, 4'hF, 2'b00, 0);
        axi_wr("db_mask", 12'h014, 32'h4, 4'hF, 2'b00, 0);
        gpio_in_raw[2] = 1'b1;
        step(3);
        gpio_in_raw[2] = 1'b0;
        step(12);
        axi_rd("db_short_stat", 12'h018, 32'h0, 2'b00);
        check("db_short_irq", irq, 0);
        gpio_in_raw[2] = 1'b1;
        step(4);
        gpio_in_raw[2] = 1'b0;
        step(12);
        axi_rd("db_long_stat", 12'h018, 32'h4, 2'b00);
        check("db_long_irq", irq, 1);
        axi_wr("db_clr", 12'h01C, 32'h4, 4'hF, 2'b00, 0);
        gpio_in_raw[2] = 1'b1;
        step(12);
        axi_rd("db_in", 12'h010, 32'h4, 2'b00);
        axi_wr("db_off", 12'h030, 32'h0, 4'hF, 2'b00, 0);
        gpio_in_raw[2] = 1'b0;
        step(6);
        axi_wr("clr_all", 12'h01C, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
        axi_rd("clr_all_stat", 12'h018, 32'h0, 2'b00);

        // Set-vs-clear collision on a held level source, with B back-pressure
        axi_wr("lvl_mode", 12'h020, 32'hFFFF_FFFD, 4'hF, 2'b00, 0);
        axi_wr("lvl_mask", 12'h014, 32'h2, 4'hF, 2'b00, 0);
        gpio_in_raw[1] = 1'b1;
        step(6);
        check("lvl_irq", irq, 1);
        axi_rd("lvl_stat", 12'h018, 32'h2, 2'b00);
        axi_wr("lvl_clr_hold", 12'h01C, 32'h2, 4'hF, 2'b00, 5);
        check("lvl_after_clr_irq", irq, 1);
        axi_rd("lvl_after_clr_stat", 12'h018, 32'h2, 2'b00);

        // Error decode and scratch
        axi_rd("unmapped_bank", 12'h200, 32'h0, 2'b10);
        axi_rd("unmapped_off", 12'h038, 32'h0, 2'b10);
        axi_rd("unmapped_glob", 12'hF10, 32'h0, 2'b10);
        axi_wr("scratch_wr", 12'hF0C, 32'hA5A5_5A5A, 4'hF, 2'b00, 0);
        axi_wr("scratch_strb", 12'hF0C, 32'h0000_00FF, 4'b0001, 2'b00, 0);
        axi_wr("bad_wr", 12'h23C, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        axi_rd("scratch_rb", 12'hF0C, 32'hA5A5_5AFF, 2'b00);
        axi_rd("b1_out_after_err", 12'h104, 32'h0000_F0F0, 2'b00);
        axi_wr("ro_wr", 12'h010, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);

        // Reset while a read response is held
        araddr  = 12'hF00;
        arvalid = 1'b1;
        rready  = 1'b0;
        step(1);
        arvalid = 1'b0;
        check("mid_rvalid", rvalid, 1);
        step(2);
        check("mid_rvalid_hold", rvalid, 1);
        check("mid_rdata_hold", rdata, 32'h0002_0000);
        areset = 1'b1;
        step(1);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_gpio_out", gpio_out, 0);
        areset = 1'b0;
        step(2);
        axi_rd("scratch_after_rst", 12'hF0C, 32'h0, 2'b00);
        axi_rd("lvl_pol_after_rst", 12'h028, 32'hFFFF_FFFF, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
